// File: rtl/croc_pkg.sv
// Shared definitions for the core interrupt front-end: register map, channel
// limits, mode encoding and the byte-enable helper used by the register port.
package croc_pkg;

    localparam int unsigned IrqCtrlMaxIrqs = 32;

    localparam logic [4:0] IrqCtrlPendingOffset = 5'h00;
    localparam logic [4:0] IrqCtrlEnableOffset  = 5'h04;
    localparam logic [4:0] IrqCtrlModeOffset    = 5'h08;
    localparam logic [4:0] IrqCtrlSoftOffset    = 5'h0C;
    localparam logic [4:0] IrqCtrlCtrlOffset    = 5'h10;
    localparam logic [4:0] IrqCtrlIdOffset      = 5'h14;

    typedef enum logic {
        IrqLevel = 1'b0,
        IrqEdge  = 1'b1
    } irq_mode_e;

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/core_irq_chan.sv
// One interrupt channel: input synchroniser, edge register and pending latch.
// The edge register tracks in every mode so a mode switch never fabricates an edge.
module core_irq_chan
    import croc_pkg::*;
#(
    parameter int unsigned SyncStages = 2
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      irq_i,
    input  irq_mode_e mode_i,
    input  logic      set_i,
    input  logic      clr_i,
    output logic      pending_o
);

    logic w_sync;
    logic r_prev;
    logic r_pend;

    if (SyncStages == 0) begin : g_nosync
        assign w_sync = irq_i;
    end else begin : g_sync
        logic [SyncStages-1:0] r_sync;
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_sync <= '0;
            end else begin
                r_sync[0] <= irq_i;
                for (int k = 1; k < int'(SyncStages); k++) begin
                    r_sync[k] <= r_sync[k-1];
                end
            end
        end
        assign w_sync = r_sync[SyncStages-1];
    end

    // In edge mode a new edge or software set beats a simultaneous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prev <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            r_prev <= w_sync;
            if (mode_i == IrqLevel) begin
                r_pend <= w_sync;
            end else if ((w_sync & ~r_prev) | set_i) begin
                r_pend <= 1'b1;
            end else if (clr_i) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign pending_o = r_pend;

endmodule

// File: rtl/core_irq_ctrl.sv
// Interrupt front-end: per-channel latches, register port, fold onto the core's
// 16 fast lines and lowest-index IRQ_ID encoder.
module core_irq_ctrl
    import croc_pkg::*;
#(
    parameter int unsigned NumIrqs    = 16,
    parameter int unsigned SyncStages = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NumIrqs-1:0] irqs_i,
    input  logic               cfg_req_i,
    output logic               cfg_gnt_o,
    input  logic               cfg_we_i,
    input  logic [3:0]         cfg_be_i,
    input  logic [31:0]        cfg_addr_i,
    input  logic [31:0]        cfg_wdata_i,
    output logic               cfg_rvalid_o,
    output logic [31:0]        cfg_rdata_o,
    output logic               cfg_err_o,
    output logic [15:0]        irq_fast_o,
    output logic               software_irq_o,
    output logic               irq_pending_o
);

    localparam logic [31:0] ValidMask = (NumIrqs >= IrqCtrlMaxIrqs) ? 32'hFFFF_FFFF
                                        : ((32'd1 << NumIrqs) - 32'd1);

    logic [31:0]        r_enable;
    logic [31:0]        r_mode;
    logic               r_ctrl;
    logic               r_rvalid;
    logic [31:0]        r_rdata;
    logic               r_err;
    logic [15:0]        r_fast;
    logic               r_any;

    logic [NumIrqs-1:0] w_pend;
    logic [31:0]        w_pend32;
    logic [31:0]        w_active;
    logic [4:0]         w_offset;
    logic               w_err;
    logic               w_wr;
    logic [31:0]        w_bemask;
    logic [31:0]        w_clr;
    logic [31:0]        w_set;
    logic [31:0]        w_rdata;
    logic [4:0]         w_id;
    logic               w_id_valid;
    logic               w_unused;

    assign cfg_gnt_o = cfg_req_i;
    assign w_offset  = {cfg_addr_i[4:2], 2'b00};
    assign w_err     = (cfg_addr_i[4:3] == 2'b11);
    assign w_wr      = cfg_req_i & cfg_we_i & ~w_err;
    assign w_bemask  = be_to_mask(cfg_be_i) & ValidMask;
    assign w_clr     = (w_wr && w_offset == IrqCtrlPendingOffset) ? (cfg_wdata_i & w_bemask) : '0;
    assign w_set     = (w_wr && w_offset == IrqCtrlSoftOffset) ? (cfg_wdata_i & w_bemask) : '0;
    assign w_unused  = ^{cfg_addr_i[31:5], cfg_addr_i[1:0], r_mode, w_clr, w_set};

    for (genvar i = 0; i < int'(NumIrqs); i++) begin : g_chan
        core_irq_chan #(
            .SyncStages (SyncStages)
        ) u_chan (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .irq_i     (irqs_i[i]),
            .mode_i    (irq_mode_e'(r_mode[i])),
            .set_i     (w_set[i]),
            .clr_i     (w_clr[i]),
            .pending_o (w_pend[i])
        );
    end

    always_comb begin
        w_pend32 = '0;
        w_pend32[NumIrqs-1:0] = w_pend;
    end

    assign w_active = w_pend32 & r_enable;

    // Scanning downwards leaves the lowest active index as the final winner.
    always_comb begin
        w_id_valid = 1'b0;
        w_id       = '0;
        for (int i = 31; i >= 0; i--) begin
            if (w_active[i]) begin
                w_id_valid = 1'b1;
                w_id       = 5'(i);
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_offset)
            IrqCtrlPendingOffset: w_rdata = w_pend32;
            IrqCtrlEnableOffset:  w_rdata = r_enable;
            IrqCtrlModeOffset:    w_rdata = r_mode;
            IrqCtrlCtrlOffset:    w_rdata = {31'b0, r_ctrl};
            IrqCtrlIdOffset:      w_rdata = {w_id_valid, 26'b0, w_id};
            default:              w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_enable <= '0;
            r_mode   <= '0;
            r_ctrl   <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_fast   <= '0;
            r_any    <= 1'b0;
        end else begin
            r_rvalid <= cfg_req_i;
            r_err    <= cfg_req_i & w_err;
            r_rdata  <= (cfg_req_i & ~cfg_we_i & ~w_err) ? w_rdata : '0;
            if (w_wr) begin
                case (w_offset)
                    IrqCtrlEnableOffset: r_enable <= (r_enable & ~w_bemask) | (cfg_wdata_i & w_bemask);
                    IrqCtrlModeOffset:   r_mode   <= (r_mode & ~w_bemask) | (cfg_wdata_i & w_bemask);
                    IrqCtrlCtrlOffset:   if (cfg_be_i[0]) r_ctrl <= cfg_wdata_i[0];
                    default: ;
                endcase
            end
            r_fast <= w_active[15:0] | w_active[31:16];
            r_any  <= |w_active;
        end
    end

    assign cfg_rvalid_o   = r_rvalid;
    assign cfg_rdata_o    = r_rdata;
    assign cfg_err_o      = r_err;
    assign irq_fast_o     = r_fast;
    assign software_irq_o = r_ctrl;
    assign irq_pending_o  = r_any;

endmodule

// File: tb/tb_core_irq_ctrl.sv
// Directed bench for core_irq_ctrl (20 channels, 2 sync stages): the driver
// queues expected responses, a negedge monitor pops and compares them.
module tb_core_irq_ctrl;

    localparam int NUM_IRQS = 20;
    localparam int SYNC     = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NUM_IRQS-1:0] irqs;
    logic                req;
    logic                gnt;
    logic                we;
    logic [3:0]          be;
    logic [31:0]         addr;
    logic [31:0]         wdata;
    logic                rvalid;
    logic [31:0]         rdata;
    logic                err;
    logic [15:0]         fast;
    logic                sw_irq;
    logic                any_pend;

    logic [31:0] exp_q[$];
    logic        exp_err_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    core_irq_ctrl #(
        .NumIrqs    (NUM_IRQS),
        .SyncStages (SYNC)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .irqs_i         (irqs),
        .cfg_req_i      (req),
        .cfg_gnt_o      (gnt),
        .cfg_we_i       (we),
        .cfg_be_i       (be),
        .cfg_addr_i     (addr),
        .cfg_wdata_i    (wdata),
        .cfg_rvalid_o   (rvalid),
        .cfg_rdata_o    (rdata),
        .cfg_err_o      (err),
        .irq_fast_o     (fast),
        .software_irq_o (sw_irq),
        .irq_pending_o  (any_pend)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Response monitor: every granted request must answer exactly one cycle later.
    always @(negedge clk) begin
        if (rvalid) begin
            if (exp_q.size() == 0) begin
                chk("spurious rvalid", 32'(rvalid), 32'd0);
            end else begin
                chk("rdata", rdata, exp_q.pop_front());
                chk("err", 32'(err), 32'(exp_err_q.pop_front()));
            end
        end else if (exp_q.size() != 0) begin
            chk("missing rvalid", 32'(rvalid), 32'd1);
            void'(exp_q.pop_front());
            void'(exp_err_q.pop_front());
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [31:0] exp_rd,
                       input logic exp_err, input bit expect_rsp);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        #1;
        chk("gnt", 32'(gnt), 32'd1);
        @(posedge clk);
        if (expect_rsp) begin
            exp_q.push_back(w ? 32'd0 : exp_rd);
            exp_err_q.push_back(exp_err);
        end
        #1;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp_rd);
        bus(1'b0, a, 32'd0, 4'h0, exp_rd, 1'b0, 1'b1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        bus(1'b1, a, d, b, 32'd0, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; irqs = '0; req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
        cyc(2);
        rst = 1'b0;

        // Reset state
        chk("reset fast", 32'(fast), 32'd0);
        chk("reset swirq", 32'(sw_irq), 32'd0);
        chk("reset pending", 32'(any_pend), 32'd0);
        chk("reset rvalid", 32'(rvalid), 32'd0);
        chk("reset rdata", rdata, 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("idle gnt", 32'(gnt), 32'd0);
        for (int a = 0; a < 6; a++) rd(32'(a * 4), 32'd0);

        // Bits above NumIrqs, byte enables
        wr(32'h04, 32'hFFFF_FFFF, 4'hF);
        rd(32'h04, 32'h000F_FFFF);
        wr(32'h04, 32'h0, 4'b0010);
        rd(32'h04, 32'h000F_00FF);

        // Edge mode channel 4, one-cycle pulse
        wr(32'h04, 32'h10, 4'hF);
        wr(32'h08, 32'h10, 4'hF);
        irqs[4] = 1'b1;
        cyc(1);
        irqs[4] = 1'b0;
        cyc(2);
        chk("edge4 fast t+2", 32'(fast), 32'h0);
        cyc(1);
        chk("edge4 fast t+3", 32'(fast), 32'h10);
        chk("edge4 irq_pending", 32'(any_pend), 32'd1);
        cyc(3);
        chk("edge4 fast held", 32'(fast), 32'h10);
        rd(32'h14, 32'h8000_0004);
        rd(32'h00, 32'h10);
        wr(32'h00, 32'h10, 4'hF);
        chk("w1c fast same cycle", 32'(fast), 32'h10);
        cyc(1);
        chk("w1c fast cleared", 32'(fast), 32'h0);
        rd(32'h00, 32'h0);
        rd(32'h14, 32'h0);

        // Level mode channel 3
        wr(32'h04, 32'h08, 4'hF);
        irqs[3] = 1'b1;
        cyc(4);
        chk("level3 fast", 32'(fast), 32'h08);
        rd(32'h00, 32'h08);
        wr(32'h00, 32'h08, 4'hF);
        cyc(2);
        rd(32'h00, 32'h08);
        chk("level3 w1c ignored", 32'(fast), 32'h08);
        irqs[3] = 1'b0;
        cyc(3);
        chk("level3 fast t+2", 32'(fast), 32'h08);
        cyc(1);
        chk("level3 fast dropped", 32'(fast), 32'h0);

        // Channels 2 and 18 in edge mode share fast line 2
        wr(32'h08, 32'h0004_0004, 4'hF);
        wr(32'h04, 32'h0004_0004, 4'hF);
        wr(32'h0C, 32'h0004_0000, 4'hF);
        chk("soft fast same cycle", 32'(fast), 32'h0);
        cyc(1);
        chk("soft18 fast", 32'(fast), 32'h04);
        rd(32'h14, 32'h8000_0012);
        rd(32'h00, 32'h0004_0000);
        rd(32'h0C, 32'h0);
        wr(32'h0C, 32'h08, 4'hF);
        rd(32'h00, 32'h0004_0000);
        wr(32'h0C, 32'h04, 4'hF);
        rd(32'h14, 32'h8000_0002);
        rd(32'h00, 32'h0004_0004);
        wr(32'h00, 32'h04, 4'b0010);
        rd(32'h00, 32'h0004_0004);
        wr(32'h00, 32'h0004_0004, 4'hF);
        rd(32'h00, 32'h0);

        // Edge on 18 lands in the same cycle as its W1C: set wins
        irqs[18] = 1'b1;
        cyc(2);
        wr(32'h00, 32'h0004_0000, 4'hF);
        rd(32'h00, 32'h0004_0000);
        cyc(3);
        rd(32'h00, 32'h0004_0000);
        chk("set-wins fast", 32'(fast), 32'h04);
        irqs[18] = 1'b0;

        // CTRL with byte enables, error offsets
        wr(32'h10, 32'h1, 4'b0000);
        chk("ctrl be0 swirq", 32'(sw_irq), 32'd0);
        rd(32'h10, 32'h0);
        wr(32'h10, 32'h1, 4'b0001);
        chk("ctrl swirq", 32'(sw_irq), 32'd1);
        rd(32'h10, 32'h1);
        bus(1'b0, 32'h18, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
        bus(1'b1, 32'h1C, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 1'b1);
        rd(32'h04, 32'h0004_0004);

        // Reset with a read in flight
        chk("pre-reset fast", 32'(fast), 32'h04);
        rst = 1'b1;
        bus(1'b0, 32'h00, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("reset drops rvalid", 32'(rvalid), 32'd0);
        chk("mid-reset fast", 32'(fast), 32'h0);
        chk("mid-reset swirq", 32'(sw_irq), 32'd0);
        chk("mid-reset pending", 32'(any_pend), 32'd0);
        rd(32'h00, 32'h0);
        rd(32'h10, 32'h0);
        rd(32'h04, 32'h0);
        rd(32'h08, 32'h0);

        cyc(2);
        chk("queue drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
